// File: rtl/tetris_pkg.sv
// Shared tetris field definitions: field geometry, row word type and the
// row-collapse sequencer states.
package tetris_pkg;

  localparam int unsigned BRICK_X_CNT = 10;
  localparam int unsigned BRICK_Y_CNT = 20;
  localparam int unsigned COLOR_W     = 3;
  localparam int unsigned ROW_W       = BRICK_X_CNT * COLOR_W;
  localparam int unsigned ROW_IDX_W   = $clog2(BRICK_Y_CNT);
  localparam int unsigned PTR_W       = ROW_IDX_W + 1;
  localparam int unsigned CNT_W       = $clog2(BRICK_Y_CNT + 1);

  typedef logic [BRICK_X_CNT-1:0][COLOR_W-1:0] field_row_t;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SCAN_RD,
    ST_SCAN_WT,
    ST_FLASH,
    ST_RD,
    ST_WT,
    ST_WR,
    ST_FILL,
    ST_DONE
  } state_e;

endpackage

// File: rtl/row_full_detect.sv
// Flags a field row in which every cell holds a non-zero colour.
module row_full_detect
  import tetris_pkg::*;
(
  input  field_row_t row,
  output logic       full_c
);

  always_comb begin
    full_c = 1'b1;
    for (int unsigned i = 0; i < BRICK_X_CNT; i++) begin
      if (row[i] == '0) full_c = 1'b0;
    end
  end

endmodule

// File: rtl/field_row_collapse.sv
// Removes full rows from the field RAM and shifts the rows above them down,
// yielding the RAM port to the renderer. Option macro: FIELD_COLLAPSE_FLASH_EN.
module field_row_collapse
  import tetris_pkg::*;
#(
  parameter int unsigned FLASH_FRAMES = 30
) (
  input  logic                 clk,
  input  logic                 rst_i,
  input  logic                 start_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [CNT_W-1:0]     cleared_cnt_o,
  output logic [BRICK_Y_CNT-1:0] full_rows_o,
  input  logic                 frame_tick_i,
  input  logic                 draw_req_i,
  output logic [ROW_IDX_W-1:0] mem_addr_o,
  output logic                 mem_rd_o,
  output logic                 mem_wr_o,
  output logic [ROW_W-1:0]     mem_wdata_o,
  input  logic [ROW_W-1:0]     mem_rdata_i
);

  localparam logic [PTR_W-1:0] PTR_TOP = PTR_W'(BRICK_Y_CNT - 1);

  state_e           state_q, state_d;
  logic [PTR_W-1:0] rd_q, rd_d, wr_q, wr_d, rd_dec, wr_dec;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  field_row_t       row_q, row_d, word;
  logic             held_q, held_d;
  logic             word_full;

`ifdef FIELD_COLLAPSE_FLASH_EN
  localparam int unsigned TICK_W = $clog2(FLASH_FRAMES + 1);
  logic [BRICK_Y_CNT-1:0] mask_q, mask_d;
  logic [TICK_W-1:0]      tick_q, tick_d;
  assign full_rows_o = mask_q;
`else
  logic unused_flash;
  assign unused_flash = frame_tick_i ^ (FLASH_FRAMES == 0);
  assign full_rows_o  = '0;
`endif

  // A stalled wait state keeps the word it captured on its first cycle,
  // since the RAM output then belongs to the renderer.
  assign word   = held_q ? row_q : field_row_t'(mem_rdata_i);
  assign rd_dec = rd_q - PTR_W'(1);
  assign wr_dec = wr_q - PTR_W'(1);

  row_full_detect u_full (
    .row    (word),
    .full_c (word_full)
  );

  function automatic state_e tail_state(input logic [PTR_W-1:0] wr_n);
    return wr_n[PTR_W-1] ? ST_DONE : ST_FILL;
  endfunction

  always_comb begin
    state_d     = state_q;
    rd_d        = rd_q;
    wr_d        = wr_q;
    cnt_d       = cnt_q;
    row_d       = row_q;
    held_d      = 1'b0;
    mem_rd_o    = 1'b0;
    mem_wr_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
`ifdef FIELD_COLLAPSE_FLASH_EN
    mask_d      = mask_q;
    tick_d      = tick_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          rd_d  = PTR_TOP;
          wr_d  = PTR_TOP;
          cnt_d = '0;
`ifdef FIELD_COLLAPSE_FLASH_EN
          mask_d  = '0;
          state_d = ST_SCAN_RD;
`else
          state_d = ST_RD;
`endif
        end
      end
`ifdef FIELD_COLLAPSE_FLASH_EN
      ST_SCAN_RD: begin
        mem_addr_o = rd_q[ROW_IDX_W-1:0];
        if (!draw_req_i) begin
          mem_rd_o = 1'b1;
          state_d  = ST_SCAN_WT;
        end
      end
      ST_SCAN_WT: begin
        row_d = word;
        if (draw_req_i) begin
          held_d = 1'b1;
        end else begin
          if (word_full) mask_d[rd_q[ROW_IDX_W-1:0]] = 1'b1;
          rd_d = rd_dec;
          if (!rd_dec[PTR_W-1]) begin
            state_d = ST_SCAN_RD;
          end else if (mask_d == '0) begin
            state_d = ST_DONE;
          end else begin
            tick_d  = '0;
            state_d = ST_FLASH;
          end
        end
      end
      ST_FLASH: begin
        if (frame_tick_i) begin
          if (tick_q == TICK_W'(FLASH_FRAMES - 1)) begin
            mask_d  = '0;
            rd_d    = PTR_TOP;
            wr_d    = PTR_TOP;
            state_d = ST_RD;
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end
      end
`endif
      ST_RD: begin
        mem_addr_o = rd_q[ROW_IDX_W-1:0];
        if (!draw_req_i) begin
          mem_rd_o = 1'b1;
          state_d  = ST_WT;
        end
      end
      ST_WT: begin
        row_d = word;
        if (draw_req_i) begin
          held_d = 1'b1;
        end else if (word_full) begin
          cnt_d   = cnt_q + CNT_W'(1);
          rd_d    = rd_dec;
          state_d = rd_dec[PTR_W-1] ? tail_state(wr_q) : ST_RD;
        end else if (wr_q == rd_q) begin
          rd_d    = rd_dec;
          wr_d    = wr_dec;
          state_d = rd_dec[PTR_W-1] ? tail_state(wr_dec) : ST_RD;
        end else begin
          state_d = ST_WR;
        end
      end
      ST_WR: begin
        mem_addr_o  = wr_q[ROW_IDX_W-1:0];
        mem_wdata_o = row_q;
        if (!draw_req_i) begin
          mem_wr_o = 1'b1;
          rd_d     = rd_dec;
          wr_d     = wr_dec;
          state_d  = rd_dec[PTR_W-1] ? tail_state(wr_dec) : ST_RD;
        end
      end
      ST_FILL: begin
        mem_addr_o = wr_q[ROW_IDX_W-1:0];
        if (!draw_req_i) begin
          mem_wr_o = 1'b1;
          wr_d     = wr_dec;
          if (wr_dec[PTR_W-1]) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      rd_q          <= '0;
      wr_q          <= '0;
      cnt_q         <= '0;
      row_q         <= '0;
      held_q        <= 1'b0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      cleared_cnt_o <= '0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      held_q  <= held_d;
      busy_o  <= (state_d != ST_IDLE) && (state_d != ST_DONE);
      done_o  <= (state_d == ST_DONE);
      if (state_d == ST_DONE) cleared_cnt_o <= cnt_d;
    end
  end

`ifdef FIELD_COLLAPSE_FLASH_EN
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      mask_q <= '0;
      tick_q <= '0;
    end else begin
      mask_q <= mask_d;
      tick_q <= tick_d;
    end
  end
`endif

endmodule
